// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data ports; data has priority, IF is starvation-guarded.
// Latency: grant in IDLE, mem_req next cycle, ready one cycle after ack/timeout; requesters stall until their ready pulse.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_rdata,
  output logic                  if_ready,
  output logic                  if_stall,
  input  logic                  dm_ren,
  input  logic                  dm_wen,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [31:0]           dm_wdata,
  output logic [31:0]           dm_rdata,
  output logic                  dm_ready,
  output logic                  dm_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic                  owner,
  output logic                  bus_err,
  input  logic                  err_clr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [3:0] starve_cnt;
  logic [7:0] tmo_cnt;
  logic       dm_any;
  logic       grant_if;
  logic       grant_dm;
  logic       timeout_hit;

  assign dm_any = dm_ren | dm_wen;

  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state == ST_IDLE) begin
      if (dm_any && if_req && (starve_cnt == STARVE_MAX)) grant_if = 1'b1;
      else if (dm_any)                                    grant_dm = 1'b1;
      else if (if_req)                                    grant_if = 1'b1;
    end
  end

  // tmo_cnt counts completed BUSY cycles, so the last allowed cycle is TIMEOUT-1
  assign timeout_hit = (state == ST_BUSY) && !mem_ack && (tmo_cnt == TMO_LAST);

  assign if_stall = if_req & ~if_ready;
  assign dm_stall = dm_any & ~dm_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      starve_cnt <= 4'd0;
      tmo_cnt    <= 8'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      owner      <= 1'b0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
      if_rdata   <= 32'd0;
      dm_rdata   <= 32'd0;
      bus_err    <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_if || grant_dm) begin
            state    <= ST_BUSY;
            mem_req  <= 1'b1;
            owner    <= grant_dm;
            mem_we   <= grant_dm & dm_wen;
            mem_addr <= grant_dm ? dm_addr : if_addr;
            if (grant_dm) mem_wdata <= dm_wdata;
          end
          if (!if_req || grant_if)
            starve_cnt <= 4'd0;
          else if (grant_dm && (starve_cnt < STARVE_MAX))
            starve_cnt <= starve_cnt + 4'd1;
        end
        ST_BUSY: begin
          if (mem_ack || timeout_hit) begin
            state   <= ST_DONE;
            mem_req <= 1'b0;
            tmo_cnt <= 8'd0;
            if (owner) dm_ready <= 1'b1;
            else       if_ready <= 1'b1;
            // aborted reads return zero so a stale word is never mistaken for data
            if (!mem_we) begin
              if (owner) dm_rdata <= mem_ack ? mem_rdata : 32'd0;
              else       if_rdata <= mem_ack ? mem_rdata : 32'd0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (timeout_hit)  bus_err <= 1'b1;
      else if (err_clr) bus_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int LIM = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [31:0]   if_rdata;
  logic          if_ready, if_stall;
  logic          dm_ren = 1'b0, dm_wen = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [31:0]   dm_wdata = '0;
  logic [31:0]   dm_rdata;
  logic          dm_ready, dm_stall;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          owner, bus_err;
  logic          err_clr = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .dm_ren(dm_ren), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .owner(owner), .bus_err(bus_err), .err_clr(err_clr)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Transaction-level reference: one access at a time, each ending with a single ready cycle
  logic        m_busy, m_done, m_owner, m_we, m_err, m_if_rdy, m_dm_rdy;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  int          m_cyc, m_lat, m_starve;
  logic        prev_if_rdy, prev_dm_rdy;
  int          mem_mode;   // 0 manual ack, 1 ack at m_lat, 2 random latency with stray acks

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_owner = 0; m_we = 0; m_err = 0; m_if_rdy = 0; m_dm_rdy = 0;
    m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_dm_rdata = 0;
    m_cyc = 0; m_lat = 0; m_starve = 0; prev_if_rdy = 0; prev_dm_rdy = 0;
  endtask

  task automatic model_tick();
    logic dmr, gi, gd, tmo, ri, rd;
    dmr = dm_ren | dm_wen;
    gi = 0; gd = 0; tmo = 0; ri = 0; rd = 0;
    if (m_busy) begin
      m_cyc++;
      if (mem_ack || m_cyc >= TMO) begin
        tmo = !mem_ack;
        m_busy = 0;
        m_done = 1;
        if (m_owner) rd = 1; else ri = 1;
        if (!m_we) begin
          if (m_owner) m_dm_rdata = tmo ? 32'h0 : mem_rdata;
          else         m_if_rdata = tmo ? 32'h0 : mem_rdata;
        end
        if (tmo) m_err = 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end else begin
      if (dmr && if_req && m_starve == LIM) gi = 1;
      else if (dmr) gd = 1;
      else if (if_req) gi = 1;
      if (gi || gd) begin
        m_busy = 1; m_cyc = 0; m_owner = gd; m_we = gd & dm_wen;
        m_addr = gd ? dm_addr : if_addr;
        if (gd) m_wdata = dm_wdata;
        if (mem_mode == 2) m_lat = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
        else m_lat = 0;
      end
      if (!if_req || gi) m_starve = 0;
      else if (gd && m_starve < LIM) m_starve++;
    end
    if (err_clr && !tmo) m_err = 0;
    m_if_rdy = ri;
    m_dm_rdy = rd;
  endtask

  // Called at posedge+1 with inputs for this cycle set; checks, advances model, ends at next posedge+1
  task automatic step();
    if (mem_mode != 0) begin
      mem_ack = m_busy && (m_cyc == m_lat);
      if (mem_mode == 2) begin
        mem_rdata = $urandom();
        if (!m_busy) mem_ack = ($urandom_range(0, 3) == 0);
      end
    end
    #1;
    check_eq("mem_req", mem_req, m_busy);
    check_eq("owner", owner, m_owner);
    check_eq("mem_we", mem_we, m_we);
    check_eq("mem_addr", mem_addr, m_addr);
    if (m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
    check_eq("if_ready", if_ready, m_if_rdy);
    check_eq("dm_ready", dm_ready, m_dm_rdy);
    check_eq("if_rdata", if_rdata, m_if_rdata);
    check_eq("dm_rdata", dm_rdata, m_dm_rdata);
    check_eq("bus_err", bus_err, m_err);
    check_eq("if_stall", if_stall, if_req & ~m_if_rdy);
    check_eq("dm_stall", dm_stall, (dm_ren | dm_wen) & ~m_dm_rdy);
    prev_if_rdy = m_if_rdy;
    prev_dm_rdy = m_dm_rdy;
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_dm_op(input int k);
    dm_ren   = (k == 1) || (k == 3);
    dm_wen   = (k >= 2);
    dm_addr  = $urandom() & 32'hFFFF_FFFC;
    dm_wdata = $urandom();
  endtask

  task automatic drive_random();
    if (if_req && prev_if_rdy) begin
      if_req  = ($urandom_range(0, 2) != 0);
      if_addr = $urandom() & 32'hFFFF_FFFC;
    end else if (!if_req && $urandom_range(0, 2) == 0) begin
      if_req  = 1'b1;
      if_addr = $urandom() & 32'hFFFF_FFFC;
    end
    if ((dm_ren | dm_wen) && prev_dm_rdy) new_dm_op(int'($urandom_range(0, 3)));
    else if (!(dm_ren | dm_wen) && $urandom_range(0, 2) == 0) new_dm_op(int'($urandom_range(1, 3)));
    err_clr = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ng, seen, pulses;
    logic prev_req;
    logic [31:0] saved;
    mem_mode = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_owner", owner, 0);
    check_eq("rst_bus_err", bus_err, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_if_rdata", if_rdata, 0);
    check_eq("rst_dm_rdata", dm_rdata, 0);
    check_eq("rst_ready", {if_ready, dm_ready}, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // single fetch, ack in first BUSY cycle
    if_req = 1; if_addr = 32'h40; mem_rdata = 32'h2008000A;
    step();
    check_eq("fetch_mem_req_c1", mem_req, 1);
    step();
    check_eq("fetch_ready_c2", if_ready, 1);
    check_eq("fetch_rdata", if_rdata, 32'h2008000A);
    check_eq("fetch_stall_c2", if_stall, 0);
    step();
    if_req = 0;
    repeat (2) step();

    // simultaneous requests: data first, IF granted in cycle 3
    if_req = 1; if_addr = 32'h80; dm_ren = 1; dm_addr = 32'h100; mem_rdata = 32'h55;
    step();
    check_eq("simul_owner_c1", owner, 1);
    step();
    check_eq("simul_dm_ready_c2", dm_ready, 1);
    check_eq("simul_dm_rdata", dm_rdata, 32'h55);
    step();
    dm_ren = 0; mem_rdata = 32'h1234_5678;
    step();
    check_eq("simul_if_owner_c4", owner, 0);
    step();
    check_eq("simul_if_ready_c5", if_ready, 1);
    step();
    if_req = 0;
    repeat (2) step();

    // store leaves dm_rdata alone
    saved = dm_rdata;
    dm_wen = 1; dm_addr = 32'h200; dm_wdata = 32'hCAFEF00D;
    step();
    check_eq("store_mem_we", mem_we, 1);
    check_eq("store_mem_wdata", mem_wdata, 32'hCAFEF00D);
    check_eq("store_mem_addr", mem_addr, 32'h200);
    step();
    check_eq("store_dm_ready", dm_ready, 1);
    check_eq("store_dm_rdata", dm_rdata, saved);
    step();
    dm_wen = 0;
    repeat (2) step();

    // starvation: continuous stores with a held fetch
    if_req = 1; if_addr = 32'h300; dm_wen = 1; dm_addr = 32'h600; dm_wdata = $urandom();
    ng = 0; prev_req = 0;
    for (int i = 0; i < 80 && ng < 10; i++) begin
      if (prev_dm_rdy) begin dm_wdata = $urandom(); dm_addr = dm_addr + 32'd4; end
      if (mem_req && !prev_req) begin
        check_eq($sformatf("starve_grant%0d", ng), owner, (ng % 5 == 4) ? 0 : 1);
        ng++;
      end
      prev_req = mem_req;
      step();
    end
    check_eq("starve_grants", ng, 10);
    if_req = 0; dm_wen = 0;
    repeat (4) step();

    // timeout with no ack
    mem_mode = 0; mem_ack = 0;
    dm_ren = 1; dm_addr = 32'h400;
    n = 0; seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (mem_req) n++;
      if (dm_ready) seen = 1;
      else step();
    end
    check_eq("tmo_seen", seen, 1);
    check_eq("tmo_busy_cycles", n, TMO);
    check_eq("tmo_dm_rdata", dm_rdata, 0);
    check_eq("tmo_bus_err", bus_err, 1);
    step();
    dm_ren = 0; err_clr = 1;
    step();
    err_clr = 0;
    check_eq("err_clr", bus_err, 0);
    repeat (2) step();

    // random traffic
    mem_mode = 2;
    repeat (1500) begin
      drive_random();
      step();
    end
    if_req = 0; dm_ren = 0; dm_wen = 0; err_clr = 0; mem_mode = 1;
    repeat (12) step();

    // reset during BUSY drops the access; held fetch is regranted
    mem_mode = 0; mem_ack = 0;
    if_req = 1; if_addr = 32'h500; mem_rdata = 32'hA5A5_0001;
    step();
    check_eq("rmid_busy", mem_req, 1);
    rst_n = 0;
    #1;
    check_eq("rmid_mem_req", mem_req, 0);
    check_eq("rmid_bus_err", bus_err, 0);
    check_eq("rmid_ready", {if_ready, dm_ready}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    mem_mode = 1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (if_ready) pulses++;
      if (prev_if_rdy) if_req = 0;
      step();
    end
    check_eq("rmid_regrant_pulses", pulses, 1);
    check_eq("rmid_if_rdata", if_rdata, 32'hA5A5_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
